// File: rtl/evn_pkg.sv
// ============================================================================
//  evn_pkg : event bundle driven into a scope channel's evi vector
//  Rev 1.0
// ============================================================================
`default_nettype none

package evn_pkg;

   typedef struct packed {
      logic rst;
      logic str;
      logic stp;
      logic swt;
   } evn_t;

endpackage

`default_nettype wire

// File: rtl/osc_seq_pkg.sv
// ============================================================================
//  osc_seq_pkg : state encoding and default widths for the acquisition sequencer
//  Rev 1.0
// ============================================================================
`default_nettype none

package osc_seq_pkg;

   localparam int CW_DEF = 32;
   localparam int SW_DEF = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RST  = 3'd1,
      ST_ARM  = 3'd2,
      ST_WTRG = 3'd3,
      ST_WLST = 3'd4,
      ST_HOLD = 3'd5,
      ST_DONE = 3'd6
   } state_t;

endpackage

`default_nettype wire

// File: rtl/osc_seq_if.sv
// ============================================================================
//  osc_seq_if : control, configuration, scope-side and status signals of osc_seq
//  Rev 1.0
// ============================================================================
`default_nettype none

interface osc_seq_if
   import osc_seq_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int SW = SW_DEF
);

   logic          ctl_str;
   logic          ctl_stp;
   logic [SW-1:0] cfg_seg;
   logic [CW-1:0] cfg_arm;
   logic [CW-1:0] cfg_ato;
   logic [CW-1:0] cfg_hld;
   logic          acq_trg;
   logic          acq_lst;
   evn_pkg::evn_t evo;
   logic          sts_bsy;
   logic [SW-1:0] sts_seg;
   logic          sts_ato;
   logic [CW-1:0] sts_tsp;
   logic          irq;

   modport master (
      output ctl_str, ctl_stp, cfg_seg, cfg_arm, cfg_ato, cfg_hld, acq_trg, acq_lst,
      input  evo, sts_bsy, sts_seg, sts_ato, sts_tsp, irq
   );

   modport slave (
      input  ctl_str, ctl_stp, cfg_seg, cfg_arm, cfg_ato, cfg_hld, acq_trg, acq_lst,
      output evo, sts_bsy, sts_seg, sts_ato, sts_tsp, irq
   );

endinterface

`default_nettype wire

// File: rtl/osc_seq_cnt.sv
// ============================================================================
//  osc_seq_cnt : loadable down counter with zero flag, holds at zero
//  Rev 1.0
// ============================================================================
`default_nettype none

module osc_seq_cnt #(
   parameter int CW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          ld,
   input  logic [CW-1:0] val,
   output logic          zero
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (ld) begin
         cnt_d = val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/osc_seq.sv
// ============================================================================
//  osc_seq : segmented-acquisition sequencer for one scope channel
//  Optional build macro OSC_SEQ_TIMESTAMP_EN adds trigger timestamp capture.
//  Rev 1.0
// ============================================================================
`default_nettype none

module osc_seq
   import osc_seq_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int SW = SW_DEF
) (
   input  logic     clk,
   input  logic     rst,
   osc_seq_if.slave bus
);

   state_t        state_q, state_d;
   evn_pkg::evn_t evo_q, evo_d;
   logic          bsy_q, bsy_d;
   logic          ato_q, ato_d;
   logic          aen_q, aen_d;
   logic          irq_q, irq_d;
   logic [SW-1:0] seg_q, seg_d;
   logic [SW-1:0] lim_q, lim_d;
   logic [SW-1:0] seg_inc;

   logic          cnt_ld;
   logic [CW-1:0] cnt_val;
   logic          cnt_zero;
   logic          seg_end;

   osc_seq_cnt #(
      .CW (CW)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .ld   (cnt_ld),
      .val  (cnt_val),
      .zero (cnt_zero)
   );

   assign seg_inc = (&seg_q) ? seg_q : seg_q + SW'(1);

   always_comb begin
      state_d = state_q;
      evo_d   = '0;
      bsy_d   = bsy_q;
      ato_d   = ato_q;
      aen_d   = aen_q;
      irq_d   = 1'b0;
      seg_d   = seg_q;
      lim_d   = lim_q;
      cnt_ld  = 1'b0;
      cnt_val = '0;
      seg_end = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.ctl_str && !bus.ctl_stp) begin
               state_d   = ST_RST;
               evo_d.rst = 1'b1;
               lim_d     = bus.cfg_seg;
               seg_d     = '0;
               ato_d     = 1'b0;
               bsy_d     = 1'b1;
            end
         end
         ST_RST: begin
            state_d   = ST_ARM;
            evo_d.str = 1'b1;
            cnt_ld    = 1'b1;
            cnt_val   = bus.cfg_arm;
         end
         ST_ARM: begin
            if (bus.acq_lst) begin
               seg_end = 1'b1;
            end else if (cnt_zero) begin
               state_d = ST_WTRG;
               cnt_ld  = 1'b1;
               cnt_val = bus.cfg_ato;
               aen_d   = |bus.cfg_ato;
            end
         end
         ST_WTRG: begin
            // A last-sample indication here means the trigger slipped past us.
            if (bus.acq_lst) begin
               seg_end = 1'b1;
            end else if (bus.acq_trg) begin
               state_d = ST_WLST;
            end else if (aen_q && cnt_zero) begin
               state_d   = ST_WLST;
               evo_d.swt = 1'b1;
               ato_d     = 1'b1;
            end
         end
         ST_WLST: begin
            if (bus.acq_lst) begin
               seg_end = 1'b1;
            end
         end
         ST_HOLD: begin
            if (cnt_zero) begin
               state_d   = ST_RST;
               evo_d.rst = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            irq_d   = 1'b1;
            bsy_d   = 1'b0;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (seg_end) begin
         seg_d = seg_inc;
         if ((lim_q != '0) && (seg_inc == lim_q)) begin
            state_d = ST_DONE;
         end else begin
            state_d = ST_HOLD;
            cnt_ld  = 1'b1;
            cnt_val = bus.cfg_hld;
         end
      end

      // Abort overrides everything decided above, including a pending completion.
      if (bus.ctl_stp && (state_q != ST_IDLE)) begin
         state_d   = ST_IDLE;
         evo_d     = '0;
         evo_d.stp = 1'b1;
         bsy_d     = 1'b0;
         irq_d     = 1'b0;
         seg_d     = seg_q;
         ato_d     = ato_q;
         cnt_ld    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         evo_q   <= '0;
         bsy_q   <= 1'b0;
         ato_q   <= 1'b0;
         aen_q   <= 1'b0;
         irq_q   <= 1'b0;
         seg_q   <= '0;
         lim_q   <= '0;
      end else begin
         state_q <= state_d;
         evo_q   <= evo_d;
         bsy_q   <= bsy_d;
         ato_q   <= ato_d;
         aen_q   <= aen_d;
         irq_q   <= irq_d;
         seg_q   <= seg_d;
         lim_q   <= lim_d;
      end
   end

`ifdef OSC_SEQ_TIMESTAMP_EN
   logic [CW-1:0] ts_q, ts_d;
   logic [CW-1:0] tsp_q, tsp_d;
   logic          wtrg_exit;

   assign wtrg_exit = (state_q == ST_WTRG) && (state_d inside {ST_WLST, ST_HOLD, ST_DONE});

   always_comb begin
      ts_d  = ts_q + CW'(1);
      tsp_d = tsp_q;
      if (wtrg_exit) begin
         tsp_d = ts_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q  <= '0;
         tsp_q <= '0;
      end else begin
         ts_q  <= ts_d;
         tsp_q <= tsp_d;
      end
   end

   assign bus.sts_tsp = tsp_q;
`else
   assign bus.sts_tsp = '0;
`endif

   assign bus.evo     = evo_q;
   assign bus.sts_bsy = bsy_q;
   assign bus.sts_seg = seg_q;
   assign bus.sts_ato = ato_q;
   assign bus.irq     = irq_q;

endmodule

`default_nettype wire

// File: tb/tb_osc_seq.sv
// ============================================================================
//  tb_osc_seq : directed self-checking bench for osc_seq
//  Rev 1.0
// ============================================================================
`default_nettype none

module tb_osc_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   osc_seq_if #(.CW(32), .SW(16)) b ();
   osc_seq_if #(.CW(32), .SW(4))  s ();

   osc_seq #(.CW(32), .SW(16)) dut     (.clk(clk), .rst(rst), .bus(b));
   osc_seq #(.CW(32), .SW(4))  dut_sat (.clk(clk), .rst(rst), .bus(s));

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int trg_cyc = 0;
   int n_rst = 0, n_str = 0, n_stp = 0, n_swt = 0, n_irq = 0;
   int snap_str, snap_irq, snap_swt, snap_all;
   logic [31:0] exp_tsp;

   always @(negedge clk) begin
      if (b.evo.rst) n_rst++;
      if (b.evo.str) n_str++;
      if (b.evo.stp) n_stp++;
      if (b.evo.swt) n_swt++;
      if (b.irq)     n_irq++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      b.ctl_str = 0; b.ctl_stp = 0; b.cfg_seg = 0; b.cfg_arm = 0;
      b.cfg_ato = 0; b.cfg_hld = 0; b.acq_trg = 0; b.acq_lst = 0;
      s.ctl_str = 0; s.ctl_stp = 0; s.cfg_seg = 0; s.cfg_arm = 0;
      s.cfg_ato = 0; s.cfg_hld = 0; s.acq_trg = 0; s.acq_lst = 0;

      // reset state
      repeat (3) tick();
      check("rst_evo", b.evo, 4'b0000);
      check("rst_bsy", b.sts_bsy, 1'b0);
      check("rst_seg", b.sts_seg, 16'h0);
      check("rst_ato", b.sts_ato, 1'b0);
      check("rst_tsp", b.sts_tsp, 32'h0);
      check("rst_irq", b.irq, 1'b0);
      rst = 1'b0;
      cyc = 0;

      // single segment, arm=3
      b.cfg_seg = 1; b.cfg_arm = 3; b.cfg_ato = 0; b.cfg_hld = 0;
      tick();
      b.ctl_str = 1; tick(); b.ctl_str = 0;              // t0+1
      check("t1_evo_rst", b.evo, 4'b1000);
      check("t1_bsy", b.sts_bsy, 1'b1);
      tick();                                            // t0+2
      check("t1_evo_str", b.evo, 4'b0100);
      b.acq_trg = 1; tick(); b.acq_trg = 0;              // t0+3, ignored in ARM
      repeat (7) tick();                                 // t0+10
      b.acq_trg = 1; trg_cyc = cyc; tick(); b.acq_trg = 0;
      repeat (9) tick();                                 // t0+20
      b.acq_lst = 1; tick(); b.acq_lst = 0;              // t0+21
      check("t1_irq_early", b.irq, 1'b0);
      check("t1_seg_pre", b.sts_seg, 16'd1);
      tick();                                            // t0+22
      check("t1_irq", b.irq, 1'b1);
      check("t1_bsy_done", b.sts_bsy, 1'b0);
      check("t1_seg", b.sts_seg, 16'd1);
`ifdef OSC_SEQ_TIMESTAMP_EN
      exp_tsp = 32'(trg_cyc);
`else
      exp_tsp = 32'h0;
`endif
      check("t1_tsp", b.sts_tsp, exp_tsp);
      tick();
      check("t1_irq_pulse", b.irq, 1'b0);

      // three segments with holdoff 5
      b.cfg_seg = 3; b.cfg_arm = 0; b.cfg_ato = 0; b.cfg_hld = 5;
      snap_str = n_str; snap_irq = n_irq;
      b.ctl_str = 1; tick(); b.ctl_str = 0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("t2_rst%0d", k), b.evo, 4'b1000);
         tick();
         check($sformatf("t2_str%0d", k), b.evo, 4'b0100);
         tick();
         b.acq_trg = 1; tick(); b.acq_trg = 0;
         b.acq_lst = 1; tick(); b.acq_lst = 0;
         if (k < 2) begin
            check($sformatf("t2_hold%0d", k), b.evo, 4'b0000);
            repeat (6) tick();
         end
      end
      check("t2_irq_early", b.irq, 1'b0);
      tick();
      check("t2_irq", b.irq, 1'b1);
      check("t2_seg", b.sts_seg, 16'd3);
      check("t2_bsy", b.sts_bsy, 1'b0);
      tick();
      check("t2_nstr", n_str - snap_str, 3);
      check("t2_nirq", n_irq - snap_irq, 1);

      // auto-trigger, arm=2, ato=10
      b.cfg_seg = 1; b.cfg_arm = 2; b.cfg_ato = 10; b.cfg_hld = 0;
      snap_swt = n_swt;
      b.ctl_str = 1; tick(); b.ctl_str = 0;              // t0+1
      repeat (14) tick();                                // t0+15, last WTRG cycle
      check("t3_noswt_yet", b.evo, 4'b0000);
      tick();                                            // t0+16
      check("t3_swt", b.evo, 4'b0001);
      check("t3_ato", b.sts_ato, 1'b1);
      b.acq_lst = 1; tick(); b.acq_lst = 0;
      tick();
      check("t3_irq", b.irq, 1'b1);
      check("t3_ato_sticky", b.sts_ato, 1'b1);
      b.ctl_str = 1; tick(); b.ctl_str = 0;              // t0+1
      check("t3b_ato_clr", b.sts_ato, 1'b0);
      repeat (14) tick();                                // t0+15
      b.acq_trg = 1; tick(); b.acq_trg = 0;              // t0+16
      check("t3b_noswt", b.evo, 4'b0000);
      check("t3b_ato", b.sts_ato, 1'b0);
      b.acq_lst = 1; tick(); b.acq_lst = 0;
      tick();
      check("t3b_irq", b.irq, 1'b1);
      tick();
      check("t3_nswt", n_swt - snap_swt, 1);

      // abort in WLST of segment 2 of 4; ctl_str while busy is ignored
      b.cfg_seg = 4; b.cfg_arm = 0; b.cfg_ato = 0; b.cfg_hld = 0;
      snap_irq = n_irq;
      b.ctl_str = 1; tick(); b.ctl_str = 0;              // R
      tick(); tick();                                    // R+2 WTRG
      b.acq_trg = 1; tick(); b.acq_trg = 0;              // R+3 WLST
      b.acq_lst = 1; tick(); b.acq_lst = 0;              // R+4 HOLD
      tick();                                            // R+5
      check("t4_rst_seg2", b.evo, 4'b1000);
      b.ctl_str = 1; tick(); b.ctl_str = 0;              // R+6
      tick();                                            // R+7 WTRG
      b.acq_trg = 1; tick(); b.acq_trg = 0;              // R+8 WLST
      b.ctl_stp = 1; tick(); b.ctl_stp = 0;              // R+9
      check("t4_stp", b.evo, 4'b0010);
      check("t4_bsy", b.sts_bsy, 1'b0);
      check("t4_seg", b.sts_seg, 16'd1);
      check("t4_irq", b.irq, 1'b0);
      repeat (5) tick();
      check("t4_idle_evo", b.evo, 4'b0000);
      check("t4_nirq", n_irq - snap_irq, 0);

      // start and stop together while idle
      snap_all = n_rst + n_str + n_stp + n_swt + n_irq;
      b.ctl_str = 1; b.ctl_stp = 1; tick(); b.ctl_str = 0; b.ctl_stp = 0;
      check("t4b_evo", b.evo, 4'b0000);
      check("t4b_bsy", b.sts_bsy, 1'b0);
      repeat (3) tick();
      check("t4b_quiet", n_rst + n_str + n_stp + n_swt + n_irq - snap_all, 0);
      check("t4b_bsy_late", b.sts_bsy, 1'b0);

      // rst during ARM of segment 2
      b.cfg_seg = 2; b.cfg_arm = 0; b.cfg_ato = 1; b.cfg_hld = 0;
      b.ctl_str = 1; tick(); b.ctl_str = 0;              // R
      repeat (4) tick();                                 // R+4
      check("t5_swt", b.evo, 4'b0001);
      b.acq_lst = 1; tick(); b.acq_lst = 0;              // R+5
      check("t5_seg", b.sts_seg, 16'd1);
      tick(); tick();                                    // R+7 ARM
      check("t5_str", b.evo, 4'b0100);
      rst = 1; tick();
      check("t5_evo", b.evo, 4'b0000);
      check("t5_bsy", b.sts_bsy, 1'b0);
      check("t5_seg0", b.sts_seg, 16'h0);
      check("t5_ato0", b.sts_ato, 1'b0);
      check("t5_tsp0", b.sts_tsp, 32'h0);
      check("t5_irq0", b.irq, 1'b0);
      rst = 0;
      snap_all = n_rst + n_str + n_stp + n_swt + n_irq;
      repeat (10) tick();
      check("t5_idle", n_rst + n_str + n_stp + n_swt + n_irq - snap_all, 0);
      check("t5_bsy_late", b.sts_bsy, 1'b0);

      // continuous mode, 4-bit segment status saturates
      s.cfg_seg = 0; s.cfg_arm = 0; s.cfg_ato = 0; s.cfg_hld = 0;
      s.acq_lst = 1;
      s.ctl_str = 1; tick(); s.ctl_str = 0;              // t0+1
      repeat (8) tick();                                 // t0+9
      check("t6_seg3", s.sts_seg, 4'd3);
      repeat (51) tick();                                // t0+60
      check("t6_sat", s.sts_seg, 4'hF);
      check("t6_bsy", s.sts_bsy, 1'b1);
      s.ctl_stp = 1; tick(); s.ctl_stp = 0;
      s.acq_lst = 0;
      check("t6_stp", s.evo, 4'b0010);
      check("t6_bsy_end", s.sts_bsy, 1'b0);
      check("t6_seg_keep", s.sts_seg, 4'hF);
      check("t6_irq", s.irq, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/osc_seq.md
Name: osc_seq

Overview:
Segmented-acquisition sequencer for one oscilloscope channel.
- Drives the channel's event input (reset/start/stop/software trigger) and watches its trigger and end-of-acquisition indications.
- Runs N back-to-back captures with arm delay, optional auto-trigger timeout and inter-segment holdoff.
- Sits between the register/control layer and the scope channel; its evo connects to one entry of the scope's evi vector.

Parameters:
CW, 32, width of arm/timeout/holdoff counters and their config ports
SW, 16, width of segment count config and status

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ctl_str  in  1  start sequence (pulse)
ctl_stp  in  1  abort sequence (pulse)
cfg_seg  in  SW  segments per sequence; 0 = continuous until ctl_stp
cfg_arm  in  CW  arm delay after start, cycles
cfg_ato  in  CW  auto-trigger timeout, cycles; 0 = disabled
cfg_hld  in  CW  holdoff between segments, cycles
acq_trg  in  1  trigger accepted by scope channel (pulse)
acq_lst  in  1  last sample of acquisition written (scope irq, pulse)
evo  out  evn_pkg::evn_t  events to scope channel (rst/str/stp/swt pulses)
sts_bsy  out  1  sequence active
sts_seg  out  SW  completed segments in current/last sequence
sts_ato  out  1  sticky: at least one segment was auto-triggered
sts_tsp  out  CW  timestamp of last trigger (see Optional Feature)
irq  out  1  one-cycle pulse on normal sequence completion

Behaviour:
- Reset: state IDLE; evo, sts_bsy, sts_seg, sts_ato, sts_tsp, irq all 0; counters 0.
- All outputs are registered. Every evo field is a one-cycle pulse.
- Counter rule: a timed state loads value V on entry and exits when the counter reads 0, so it lasts V+1 cycles (minimum 1).
- States:
  - IDLE: on ctl_str go to RST. Latch cfg_seg, clear sts_seg and sts_ato, set sts_bsy.
  - RST: evo.rst=1 for one cycle, then go to ARM.
  - ARM: evo.str=1 on the first cycle and load cfg_arm; on count 0 go to WTRG. acq_trg is ignored here; acq_lst is handled as in WLST.
  - WTRG: load cfg_ato.
    - acq_trg: go to WLST.
    - cfg_ato!=0 and count 0 with no acq_trg that cycle: evo.swt=1, set sts_ato, go to WLST.
    - acq_trg and expiry in the same cycle: acq_trg wins, no swt.
    - acq_lst in WTRG (trigger missed): treat as trigger plus last.
  - WLST: on acq_lst, sts_seg+1 (saturates at all-ones).
    - Latched cfg_seg!=0 and sts_seg+1==cfg_seg: go to DONE.
    - Otherwise go to HOLD and load cfg_hld.
  - HOLD: on count 0 go to RST.
  - DONE: irq=1 for one cycle, clear sts_bsy, go to IDLE.
- Abort: ctl_stp in any non-IDLE state gives evo.stp=1 next cycle, goes to IDLE and clears sts_bsy. No irq; sts_seg and sts_ato are retained.
- ctl_str while busy is ignored.
- ctl_str and ctl_stp together in IDLE: stp wins, stays IDLE, no evo pulse.
- Mid-sequence rst: immediate return to reset values; no evo.stp is issued.
- cfg_arm/cfg_ato/cfg_hld are sampled at each state entry. cfg_seg is sampled only at start.

Optional Feature:
OSC_SEQ_TIMESTAMP_EN
- Defined: a free-running CW-bit cycle counter, cleared by rst, wraps naturally. sts_tsp captures it on the cycle the sequencer leaves WTRG (acq_trg, auto-trigger or missed trigger).
- Undefined: sts_tsp is tied to 0 and no counter is synthesized.

Decomposition:
- Package osc_seq_pkg: state enum typedef (IDLE, RST, ARM, WTRG, WLST, HOLD, DONE) and default width constants. evn_t comes from the existing evn_pkg.
- One sub-module, osc_seq_cnt: loadable CW-bit down counter with zero flag, shared by the ARM, WTRG and HOLD states.

Test Plan:
- Single segment: cfg_seg=1, cfg_arm=3, cfg_ato=0, ctl_str at t0.
  - evo.rst at t0+1, evo.str at t0+2, WTRG at t0+6.
  - acq_trg at t0+10 then acq_lst at t0+20 → irq at t0+22, sts_seg=1, sts_bsy=0.
- Three segments, cfg_hld=5: after each acq_lst, 6 HOLD cycles then evo.rst/evo.str again → exactly 3 str pulses, irq once, sts_seg=3.
- Auto-trigger: cfg_ato=10, acq_trg never driven → evo.swt on the 11th WTRG cycle, sts_ato=1.
  - Same setup with acq_trg on that 11th cycle → no swt, sts_ato=0.
- Abort: ctl_stp during WLST of segment 2 of 4 → evo.stp next cycle, IDLE, sts_seg=1, no irq.
  - ctl_str and ctl_stp together in IDLE → no evo activity.
- Continuous: cfg_seg=0, 70000 segments with SW=16 → sts_seg saturates at 16'hFFFF, sequence continues until ctl_stp.
- rst asserted during ARM → next cycle every output is 0 and state is IDLE.
  - With OSC_SEQ_TIMESTAMP_EN: sts_tsp equals the cycle count of the acq_trg cycle since rst release.
